// File: rtl/vga_pkg.sv
// Shared timing constants and strobe bundle type for the 640x480@60 VGA timing generator.
package vga_pkg;

  localparam int DEF_PXL_CTR_MAX       = 800;
  localparam int DEF_LINE_CTR_MAX      = 525;
  localparam int DEF_H_SYNC_MAX_PX     = 96;
  localparam int DEF_H_B_PORCH_MAX_PX  = 144;
  localparam int DEF_H_DISP_MAX_PX     = 784;
  localparam int DEF_V_SYNC_MAX_LNS    = 2;
  localparam int DEF_V_B_PORCH_MAX_LNS = 35;
  localparam int DEF_V_DISP_MAX_LNS    = 515;
  localparam int DEF_PIPE_DELAY        = 2;
  localparam logic DEF_SYNC_ACTIVE_LVL = 1'b0;

  localparam int DEF_PXL_CTR_WIDTH = $clog2(DEF_PXL_CTR_MAX);
  localparam int DEF_LN_CTR_WIDTH  = $clog2(DEF_LINE_CTR_MAX);

  // Sync fields carry the line level, not an "asserted" flag.
  typedef struct packed {
    logic h_sync;
    logic v_sync;
    logic disp_active;
    logic line_start;
    logic frame_start;
  } strobe_t;

  localparam int STROBE_W = $bits(strobe_t);

endpackage

// File: rtl/sync_delay_pipe.sv
// Fixed-depth shift register; every stage resets to RST_VAL so a reset flushes
// any partially shifted bundle.
module sync_delay_pipe #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA timing generator: undelayed pixel/line counters plus sync,
// active and start strobes delayed PIPE_DELAY cycles to line up with line-buffer output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   PXL_CTR_MAX       = DEF_PXL_CTR_MAX,
  parameter int   LINE_CTR_MAX      = DEF_LINE_CTR_MAX,
  parameter int   H_SYNC_MAX_PX     = DEF_H_SYNC_MAX_PX,
  parameter int   H_B_PORCH_MAX_PX  = DEF_H_B_PORCH_MAX_PX,
  parameter int   H_DISP_MAX_PX     = DEF_H_DISP_MAX_PX,
  parameter int   V_SYNC_MAX_LNS    = DEF_V_SYNC_MAX_LNS,
  parameter int   V_B_PORCH_MAX_LNS = DEF_V_B_PORCH_MAX_LNS,
  parameter int   V_DISP_MAX_LNS    = DEF_V_DISP_MAX_LNS,
  parameter int   PXL_CTR_WIDTH     = DEF_PXL_CTR_WIDTH,
  parameter int   LN_CTR_WIDTH      = DEF_LN_CTR_WIDTH,
  parameter logic SYNC_ACTIVE_LVL   = DEF_SYNC_ACTIVE_LVL,
  parameter int   PIPE_DELAY        = DEF_PIPE_DELAY
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     en_i,
  output logic [PXL_CTR_WIDTH-1:0] pxl_cntr_o,
  output logic [LN_CTR_WIDTH-1:0]  ln_cntr_o,
  output logic                     h_sync_o,
  output logic                     v_sync_o,
  output logic                     disp_active_o,
  output logic                     line_start_o,
  output logic                     frame_start_o
);

  if (PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be within 1..8");
  end

  localparam strobe_t STROBE_IDLE = '{
    h_sync:      ~SYNC_ACTIVE_LVL,
    v_sync:      ~SYNC_ACTIVE_LVL,
    disp_active: 1'b0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  logic [PXL_CTR_WIDTH-1:0] r_pxl;
  logic [LN_CTR_WIDTH-1:0]  r_ln;
  logic                     w_pxl_last;
  logic                     w_ln_last;
  logic                     w_h_vis;
  logic                     w_v_vis;
  strobe_t                  w_raw;
  strobe_t                  w_dly;

  assign w_pxl_last = (r_pxl == PXL_CTR_WIDTH'(PXL_CTR_MAX - 1));
  assign w_ln_last  = (r_ln  == LN_CTR_WIDTH'(LINE_CTR_MAX - 1));

  // Disabling parks the counters at the origin so re-enable starts a clean frame.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_pxl <= '0;
      r_ln  <= '0;
    end else if (!en_i) begin
      r_pxl <= '0;
      r_ln  <= '0;
    end else if (w_pxl_last) begin
      r_pxl <= '0;
      r_ln  <= w_ln_last ? '0 : r_ln + 1'b1;
    end else begin
      r_pxl <= r_pxl + 1'b1;
    end
  end

  assign w_h_vis = (r_pxl >= PXL_CTR_WIDTH'(H_B_PORCH_MAX_PX)) &&
                   (r_pxl <  PXL_CTR_WIDTH'(H_DISP_MAX_PX));
  assign w_v_vis = (r_ln  >= LN_CTR_WIDTH'(V_B_PORCH_MAX_LNS)) &&
                   (r_ln  <  LN_CTR_WIDTH'(V_DISP_MAX_LNS));

  always_comb begin
    w_raw = STROBE_IDLE;
    if (en_i) begin
      w_raw.h_sync      = (r_pxl < PXL_CTR_WIDTH'(H_SYNC_MAX_PX)) ? SYNC_ACTIVE_LVL : ~SYNC_ACTIVE_LVL;
      w_raw.v_sync      = (r_ln  < LN_CTR_WIDTH'(V_SYNC_MAX_LNS)) ? SYNC_ACTIVE_LVL : ~SYNC_ACTIVE_LVL;
      w_raw.disp_active = w_h_vis && w_v_vis;
      w_raw.line_start  = (r_pxl == '0);
      w_raw.frame_start = (r_pxl == '0) && (r_ln == '0);
    end
  end

  sync_delay_pipe #(
    .WIDTH   (STROBE_W),
    .DEPTH   (PIPE_DELAY),
    .RST_VAL (STROBE_IDLE)
  ) u_strobe_pipe (
    .i_clk   (clk_i),
    .i_rst_n (rstn_i),
    .i_d     (w_raw),
    .o_q     (w_dly)
  );

  assign pxl_cntr_o    = r_pxl;
  assign ln_cntr_o     = r_ln;
  assign h_sync_o      = w_dly.h_sync;
  assign v_sync_o      = w_dly.v_sync;
  assign disp_active_o = w_dly.disp_active;
  assign line_start_o  = w_dly.line_start;
  assign frame_start_o = w_dly.frame_start;

endmodule
